// File: rtl/maxq_table.sv
// Per-state maximum-Q table: tracks the largest Q-value and its action for every state,
// with write-first read forwarding and a sequenced clear sweep.
module maxq_table #(
    parameter int unsigned Q_WIDTH     = 14,
    parameter int unsigned NUM_STATES  = 7,
    parameter int unsigned NUM_ACTIONS = 4,
    parameter int unsigned SIGNED_Q    = 0,
    localparam int unsigned S_W = (NUM_STATES  > 1) ? $clog2(NUM_STATES)  : 1,
    localparam int unsigned A_W = (NUM_ACTIONS > 1) ? $clog2(NUM_ACTIONS) : 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               clr,
    output logic               busy,
    input  logic               upd_valid,
    input  logic [S_W-1:0]     upd_state,
    input  logic [A_W-1:0]     upd_action,
    input  logic [Q_WIDTH-1:0] upd_q,
    input  logic               rd_valid,
    input  logic [S_W-1:0]     rd_state,
    output logic               rd_out_valid,
    output logic [Q_WIDTH-1:0] rd_max_q,
    output logic [A_W-1:0]     rd_max_action,
    output logic               rd_empty
);

    localparam int unsigned SW1 = S_W + 1;
    localparam logic [S_W-1:0] LAST_PTR = S_W'(NUM_STATES - 1);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t               state;
    logic [S_W-1:0]       ptr;
    logic [Q_WIDTH-1:0]   value_mem  [NUM_STATES];
    logic [A_W-1:0]       action_mem [NUM_STATES];
    logic [NUM_STATES-1:0] full;

    logic               run_c, upd_in_c, rd_in_c, hit_c, fwd_c;
    logic [S_W-1:0]     upd_idx_c, rd_idx_c;
    logic [Q_WIDTH-1:0] cur_v_c, post_v_c, rd_v_c;
    logic [A_W-1:0]     cur_a_c, post_a_c, rd_a_c;
    logic               cur_full_c, rd_full_c, gt_c, lt_c, wr_val_c, wr_act_c;

    // Address decode; out-of-range states are redirected to entry 0 but never act on it
    always_comb begin
        run_c     = RST && (state == ST_RUN) && !clr;
        upd_in_c  = SW1'(upd_state) < SW1'(NUM_STATES);
        rd_in_c   = SW1'(rd_state)  < SW1'(NUM_STATES);
        upd_idx_c = upd_in_c ? upd_state : '0;
        rd_idx_c  = rd_in_c  ? rd_state  : '0;
        hit_c     = run_c && upd_valid && upd_in_c;
        fwd_c     = hit_c && (upd_state == rd_state);
    end

    // Update decision: new max, first write, or the tracked argmax decreasing
    always_comb begin
        cur_v_c    = value_mem[upd_idx_c];
        cur_a_c    = action_mem[upd_idx_c];
        cur_full_c = full[upd_idx_c];
        if (SIGNED_Q != 0) begin
            gt_c = $signed(upd_q) > $signed(cur_v_c);
            lt_c = $signed(upd_q) < $signed(cur_v_c);
        end else begin
            gt_c = upd_q > cur_v_c;
            lt_c = upd_q < cur_v_c;
        end
        wr_val_c = 1'b0;
        wr_act_c = 1'b0;
        if (hit_c) begin
            if (!cur_full_c || gt_c) begin
                wr_val_c = 1'b1;
                wr_act_c = 1'b1;
            end else if ((upd_action == cur_a_c) && lt_c) begin
                wr_val_c = 1'b1;
            end
        end
        post_v_c = wr_val_c ? upd_q : cur_v_c;
        post_a_c = wr_act_c ? upd_action : cur_a_c;
    end

    // Read mux with write-first forwarding
    always_comb begin
        rd_v_c    = fwd_c ? post_v_c : value_mem[rd_idx_c];
        rd_a_c    = fwd_c ? post_a_c : action_mem[rd_idx_c];
        rd_full_c = fwd_c ? 1'b1     : full[rd_idx_c];
    end

    always_ff @(posedge CLK) begin
        if (wr_val_c) value_mem[upd_idx_c]  <= upd_q;
        if (wr_act_c) action_mem[upd_idx_c] <= upd_action;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state         <= ST_CLEAR;
            ptr           <= '0;
            busy          <= 1'b1;
            rd_out_valid  <= 1'b0;
            rd_max_q      <= '0;
            rd_max_action <= '0;
            rd_empty      <= 1'b1;
        end else begin
            rd_out_valid <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    if (clr) begin
                        ptr <= '0;
                    end else begin
                        full[ptr] <= 1'b0;
                        ptr       <= ptr + S_W'(1);
                        if (ptr == LAST_PTR) begin
                            state <= ST_RUN;
                            ptr   <= '0;
                            busy  <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (clr) begin
                        state <= ST_CLEAR;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end else begin
                        if (hit_c) full[upd_idx_c] <= 1'b1;
                        if (rd_valid) begin
                            rd_out_valid <= 1'b1;
                            if (rd_in_c && rd_full_c) begin
                                rd_max_q      <= rd_v_c;
                                rd_max_action <= rd_a_c;
                                rd_empty      <= 1'b0;
                            end else begin
                                rd_max_q      <= '0;
                                rd_max_action <= '0;
                                rd_empty      <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_maxq_table.sv
// Directed bench for maxq_table: default unsigned instance plus an 8-bit signed instance.
module tb_maxq_table;

    logic        CLK, RST;
    logic        clr, busy, upd_valid, rd_valid, rd_out_valid, rd_empty;
    logic [2:0]  upd_state, rd_state;
    logic [1:0]  upd_action, rd_max_action;
    logic [13:0] upd_q, rd_max_q;

    logic        s_clr, s_busy, s_upd_valid, s_rd_valid, s_rd_out_valid, s_rd_empty;
    logic [3:0]  s_upd_state, s_rd_state;
    logic [2:0]  s_upd_action, s_rd_max_action;
    logic [7:0]  s_upd_q, s_rd_max_q;

    int n_checks = 0;
    int n_err    = 0;
    int n;

    maxq_table dut (
        .CLK(CLK), .RST(RST), .clr(clr), .busy(busy),
        .upd_valid(upd_valid), .upd_state(upd_state), .upd_action(upd_action), .upd_q(upd_q),
        .rd_valid(rd_valid), .rd_state(rd_state), .rd_out_valid(rd_out_valid),
        .rd_max_q(rd_max_q), .rd_max_action(rd_max_action), .rd_empty(rd_empty)
    );

    maxq_table #(.Q_WIDTH(8), .NUM_STATES(16), .NUM_ACTIONS(8), .SIGNED_Q(1)) dut_s (
        .CLK(CLK), .RST(RST), .clr(s_clr), .busy(s_busy),
        .upd_valid(s_upd_valid), .upd_state(s_upd_state), .upd_action(s_upd_action), .upd_q(s_upd_q),
        .rd_valid(s_rd_valid), .rd_state(s_rd_state), .rd_out_valid(s_rd_out_valid),
        .rd_max_q(s_rd_max_q), .rd_max_action(s_rd_max_action), .rd_empty(s_rd_empty)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_busy(output int cnt);
        cnt = 0;
        while (busy && cnt < 50) begin
            step();
            cnt++;
        end
    endtask

    task automatic do_upd(input logic [2:0] s, input logic [1:0] a, input logic [13:0] q);
        upd_valid = 1'b1; upd_state = s; upd_action = a; upd_q = q;
        step();
        upd_valid = 1'b0;
    endtask

    task automatic do_rd(input string tag, input logic [2:0] s, input logic e,
                         input logic [13:0] q, input logic [1:0] a);
        rd_valid = 1'b1; rd_state = s;
        step();
        rd_valid = 1'b0;
        check({tag, "_valid"}, 32'(rd_out_valid), 32'd1);
        check({tag, "_empty"}, 32'(rd_empty), 32'(e));
        check({tag, "_q"}, 32'(rd_max_q), 32'(q));
        check({tag, "_act"}, 32'(rd_max_action), 32'(a));
    endtask

    task automatic s_upd(input logic [3:0] s, input logic [2:0] a, input logic [7:0] q);
        s_upd_valid = 1'b1; s_upd_state = s; s_upd_action = a; s_upd_q = q;
        step();
        s_upd_valid = 1'b0;
    endtask

    task automatic s_rd(input string tag, input logic [3:0] s, input logic e,
                        input logic [7:0] q, input logic [2:0] a);
        s_rd_valid = 1'b1; s_rd_state = s;
        step();
        s_rd_valid = 1'b0;
        check({tag, "_valid"}, 32'(s_rd_out_valid), 32'd1);
        check({tag, "_empty"}, 32'(s_rd_empty), 32'(e));
        check({tag, "_q"}, 32'(s_rd_max_q), 32'(q));
        check({tag, "_act"}, 32'(s_rd_max_action), 32'(a));
    endtask

    initial begin
        RST = 1'b0; clr = 1'b0; upd_valid = 1'b0; rd_valid = 1'b0;
        upd_state = '0; upd_action = '0; upd_q = '0; rd_state = '0;
        s_clr = 1'b0; s_upd_valid = 1'b0; s_rd_valid = 1'b0;
        s_upd_state = '0; s_upd_action = '0; s_upd_q = '0; s_rd_state = '0;

        // Reset values and sweep length
        repeat (3) step();
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_rdv", 32'(rd_out_valid), 32'd0);
        check("rst_q", 32'(rd_max_q), 32'd0);
        check("rst_act", 32'(rd_max_action), 32'd0);
        check("rst_empty", 32'(rd_empty), 32'd1);
        RST = 1'b1;
        step();
        check("rel_busy", 32'(busy), 32'd1);
        check("rel_rdv", 32'(rd_out_valid), 32'd0);
        wait_busy(n);
        check("sweep_len", 32'(n + 1), 32'd7);
        do_rd("rd3_empty", 3'd3, 1'b1, 14'd0, 2'd0);
        step();
        check("rdv_pulse", 32'(rd_out_valid), 32'd0);

        // Max tracking, equal values do not change the entry
        do_upd(3'd2, 2'd1, 14'd100);
        do_upd(3'd2, 2'd2, 14'd50);
        do_upd(3'd2, 2'd3, 14'd200);
        do_upd(3'd2, 2'd0, 14'd200);
        do_rd("max2", 3'd2, 1'b0, 14'd200, 2'd3);

        // Tracked argmax decrease
        do_upd(3'd2, 2'd3, 14'd120);
        do_rd("dec2", 3'd2, 1'b0, 14'd120, 2'd3);
        do_upd(3'd2, 2'd1, 14'd90);
        do_rd("keep2", 3'd2, 1'b0, 14'd120, 2'd3);
        do_upd(3'd2, 2'd1, 14'd150);
        do_rd("new2", 3'd2, 1'b0, 14'd150, 2'd1);
        step();
        check("hold_rdv", 32'(rd_out_valid), 32'd0);
        check("hold_q", 32'(rd_max_q), 32'd150);

        // Write-first forwarding on an empty entry
        upd_valid = 1'b1; upd_state = 3'd5; upd_action = 2'd2; upd_q = 14'd77;
        rd_valid = 1'b1; rd_state = 3'd5;
        step();
        upd_valid = 1'b0; rd_valid = 1'b0;
        check("fwd_empty", 32'(rd_empty), 32'd0);
        check("fwd_q", 32'(rd_max_q), 32'd77);
        check("fwd_act", 32'(rd_max_action), 32'd2);
        do_rd("stor5", 3'd5, 1'b0, 14'd77, 2'd2);

        // Out-of-range state
        do_upd(3'd7, 2'd1, 14'd55);
        do_rd("oor7", 3'd7, 1'b1, 14'd0, 2'd0);
        do_rd("st0", 3'd0, 1'b1, 14'd0, 2'd0);

        // Clear with strobes presented during the sweep
        clr = 1'b1; rd_valid = 1'b1; rd_state = 3'd2;
        upd_valid = 1'b1; upd_state = 3'd4; upd_action = 2'd1; upd_q = 14'd33;
        step();
        clr = 1'b0; rd_valid = 1'b0;
        check("clr_rdv", 32'(rd_out_valid), 32'd0);
        check("clr_busy", 32'(busy), 32'd1);
        wait_busy(n);
        upd_valid = 1'b0;
        check("clr_len", 32'(n), 32'd7);
        do_rd("clr2", 3'd2, 1'b1, 14'd0, 2'd0);
        do_rd("clr4", 3'd4, 1'b1, 14'd0, 2'd0);
        do_rd("clr5", 3'd5, 1'b1, 14'd0, 2'd0);

        // Restart the sweep 3 cycles in: 3 + 7 edges of busy
        clr = 1'b1; step(); clr = 1'b0;
        step(); step();
        clr = 1'b1; step(); clr = 1'b0;
        check("restart_busy", 32'(busy), 32'd1);
        wait_busy(n);
        check("restart_len", 32'(n + 3), 32'd10);
        do_upd(3'd4, 2'd1, 14'd33);
        do_rd("after4", 3'd4, 1'b0, 14'd33, 2'd1);

        // Signed instance
        n = 0;
        while (s_busy && n < 50) begin
            step();
            n++;
        end
        check("s_busy", 32'(s_busy), 32'd0);
        s_upd(4'd9, 3'd4, 8'hEC);
        s_upd(4'd9, 3'd5, 8'hFB);
        s_rd("s9", 4'd9, 1'b0, 8'hFB, 3'd5);
        s_upd(4'd9, 3'd6, 8'h05);
        s_rd("s9pos", 4'd9, 1'b0, 8'h05, 3'd6);
        s_upd(4'd15, 3'd0, 8'h80);
        s_rd("s15", 4'd15, 1'b0, 8'h80, 3'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/maxq_table.md
# maxq_table

Parametrised per-state maximum-Q table for the pipelined Q-learning datapath. It tracks, for every state, the largest Q-value written so far and the action that produced it. It serves the maximum (value plus argmax action) of the next state to the Bellman-update stage. Compared with the single-width, 7-state maximum memory, it adds:
- configurable width, depth and action count
- a signed mode
- a tracked-argmax decrease rule
- write-first read forwarding
- a sequenced clear

## Interface
Parameters:
- Q_WIDTH, 14, Q-value width in bits.
- NUM_STATES, 7, number of table entries (≥2). S_W = max(1, clog2(NUM_STATES)).
- NUM_ACTIONS, 4, number of actions (≥2). A_W = max(1, clog2(NUM_ACTIONS)).
- SIGNED_Q, 0, 1 = Q-values compared as two's complement; 0 = unsigned.

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  synchronous, active-low reset.
- clr  in  1  pulse: start a clear sweep.
- busy  out  1  high while sweeping; table ignores upd/rd.
- upd_valid  in  1  update strobe.
- upd_state  in  S_W  state being updated.
- upd_action  in  A_W  action whose Q was computed.
- upd_q  in  Q_WIDTH  new Q-value.
- rd_valid  in  1  read strobe.
- rd_state  in  S_W  state to read (next state S(n+1)).
- rd_out_valid  out  1  read result valid.
- rd_max_q  out  Q_WIDTH  stored maximum.
- rd_max_action  out  A_W  action of stored maximum.
- rd_empty  out  1  entry has never been written since last clear.

## Operation
- Storage: per entry `value[Q_WIDTH]`, `action[A_W]`, `full` flag. value/action carry no reset; only `full` is cleared, by the sweep.
- FSM states:
  - CLEAR: each cycle, `full[ptr]<=0` and `ptr++`. After `ptr==NUM_STATES-1` is cleared, go to RUN and drop busy.
  - RUN: normal operation.
- Entry to CLEAR:
  - While RST=0: state=CLEAR, ptr=0, busy=1.
  - `clr=1` in RUN: enter CLEAR with ptr=0.
  - `clr=1` in CLEAR: restarts the sweep at ptr=0.
- Update rule (RUN, upd_valid=1, upd_state<NUM_STATES). Compare is signed when SIGNED_Q=1, otherwise unsigned.
  - `full=0`: write value=upd_q and action=upd_action, set full=1.
  - `upd_q > value`: write value and action.
  - `upd_action == action` and `upd_q < value`: write value=upd_q and keep the action. This is the tracked argmax decreasing.
  - Otherwise, including equal values: no change.
- Out-of-range state (≥NUM_STATES):
  - Update is dropped.
  - Read returns rd_empty=1, rd_max_q=0, rd_max_action=0.
- Read (RUN, rd_valid=1): registered result of entry rd_state.
  - rd_empty=!full.
  - When empty, rd_max_q=0 and rd_max_action=0.
- Write-first forwarding: if an update and a read target the same state in the same cycle, the read returns the post-update value, action and full flag.
- Updates and reads presented in CLEAR (including the cycle clr is sampled) are ignored and produce no rd_out_valid.

## Timing
- Reset values while RST=0 and on the first edge after release:
  - busy=1
  - rd_out_valid=0, rd_max_q=0, rd_max_action=0, rd_empty=1
- Sweep length: busy falls exactly NUM_STATES rising edges after the first edge with RST=1, or after the edge that sampled clr.
  - The first upd/rd accepted is in the cycle busy is low.
- Read latency is 1 cycle: rd_valid at edge k gives rd_out_valid=1 after edge k. It is one pulse per strobe, and back-to-back reads are allowed.
- rd_max_q, rd_max_action and rd_empty hold their last values when rd_out_valid=0.
- Update latency is 1 cycle: an update at edge k is visible to a read sampled at edge k via forwarding, and from storage at edge k+1 onward.
- Reset mid-sweep or mid-operation: returns to the reset values above and restarts the full sweep.
- Throughput: one update plus one read per cycle, with no stalls outside CLEAR.

## Test plan
1. **Reset sweep.** Defaults, hold RST=0 for 3 cycles, release → busy=1 for exactly 7 edges, then 0. Read state 3 → rd_empty=1, rd_max_q=0.
2. **Max tracking.** Update state 2 with (a1,100), (a2,50), (a3,200), (a0,200) → final value=200, action=3. Read → rd_out_valid one cycle after rd_valid.
3. **Argmax decrease.** From test 2, update (a3,120) → value=120, action=3. Then (a1,90) → unchanged. Then (a1,150) → value=150, action=1.
4. **Forwarding.** Same cycle: upd state 5 (a2,77) and rd state 5 on an empty entry → rd_empty=0, rd_max_q=77, rd_max_action=2.
5. **Signed mode.** SIGNED_Q=1, Q_WIDTH=8, NUM_STATES=16, NUM_ACTIONS=8. Update state 9 with (a4,-20) then (a5,-5) → value=-5 (0xFB), action=5. Update state 15 with (a0,0x80) → read returns 0x80, not empty.
6. **Clear and range.**
   - clr mid-stream: update strobes during busy are ignored.
   - After the sweep, all entries read empty.
   - upd_state=7 with NUM_STATES=7: dropped, and a read of state 7 returns empty.
   - Pulse clr again 3 cycles into the sweep → busy lasts 3+7 edges total.
